// File: rtl/dcm_pkg.sv
// Shared types and widths for the DC motor channel controller.
package dcm_pkg;
    localparam int POS_W = 24;
    localparam int SPD_W = 8;

    typedef enum logic [1:0] {IDLE, DRIVE, BRAKE, FAULT_RST} state_e;
    typedef enum logic {DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1} dir_e;

    // Right increments position, so head right whenever the target lies above.
    function automatic dir_e dir_toward(input logic [POS_W-1:0] tgt,
                                        input logic [POS_W-1:0] pos);
        return (tgt > pos) ? DIR_RIGHT : DIR_LEFT;
    endfunction
endpackage

// File: rtl/dcm_channel_ctrl_if.sv
// Register-file side of one motor channel: move commands in, status out.
interface dcm_channel_ctrl_if;
    import dcm_pkg::*;

    logic [SPD_W-1:0] cfg_speed;
    logic [POS_W-1:0] cfg_target;
    logic             cfg_load;
    logic             cfg_zero;
    logic [POS_W-1:0] position;
    logic             busy;
    logic             fault_latched;

    modport master (output cfg_speed, cfg_target, cfg_load, cfg_zero,
                    input  position, busy, fault_latched);
    modport slave  (input  cfg_speed, cfg_target, cfg_load, cfg_zero,
                    output position, busy, fault_latched);
endinterface

// File: rtl/dcm_pwm.sv
// Free-running PWM: prescaled 8-bit ramp compared against the duty,
// halved while the driver reports over-temperature.
module dcm_pwm
    import dcm_pkg::*;
#(
    parameter int PWM_DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SPD_W-1:0] speed,
    input  logic             otw,
    output logic             pwm_on
);
    localparam int PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

    logic [PRE_W-1:0] pre_cnt;
    logic [SPD_W-1:0] pwm_cnt;
    logic [SPD_W-1:0] duty;

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
        end else if (pre_cnt == PRE_W'(PWM_DIV - 1)) begin
            pre_cnt <= '0;
            pwm_cnt <= pwm_cnt + SPD_W'(1);
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    assign duty   = otw ? (speed >> 1) : speed;
    assign pwm_on = (pwm_cnt < duty);
endmodule

// File: rtl/dcm_sync2.sv
// Two-flop synchronizer cell for asynchronous pins.
module dcm_sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] sync_p0, sync_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= d;
            sync_p1 <= sync_p0;
        end
    end

    assign q = sync_p1;
endmodule

// File: rtl/dcm_channel_ctrl.sv
// Closed-loop controller for one brushed DC motor: PWM drive toward a target
// position, brake/settle before any reversal, and driver fault recovery.
module dcm_channel_ctrl
    import dcm_pkg::*;
#(
    parameter int PWM_DIV       = 4,
    parameter int SETTLE_CYCLES = 1024,
    parameter int STALL_CYCLES  = 65536,
    parameter int RESET_CYCLES  = 256
) (
    input  logic                clk,
    input  logic                reset,
    dcm_channel_ctrl_if.slave   cfg,
    input  logic                motor_pulse,
    input  logic                motor_fault,
    input  logic                motor_otw,
    output logic                motor_left,
    output logic                motor_right,
    output logic                motor_reset
);
    localparam int MAX_SR  = (SETTLE_CYCLES > RESET_CYCLES) ? SETTLE_CYCLES : RESET_CYCLES;
    localparam int TMR_MAX = (STALL_CYCLES > MAX_SR) ? STALL_CYCLES : MAX_SR;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    logic [2:0]       async_s;
    logic             pulse_s, fault_s, otw_s;
    logic             pulse_s_p2, pulse_rise_p3;
    logic             pwm_on;
    state_e           state;
    dir_e             dir_q, dir_eff;
    logic [POS_W-1:0] position_q, pos_next, tgt_q, tgt_eff;
    logic [SPD_W-1:0] spd_q;
    logic [TMR_W-1:0] tmr;
    logic             fault_latched_q;
    logic [1:0]       drive_rl;

    dcm_sync2 #(.W(3)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     ({motor_otw, motor_fault, motor_pulse}),
        .q     (async_s)
    );
    assign {otw_s, fault_s, pulse_s} = async_s;

    // Registered edge strobe: pin-to-position latency is three clocks.
    always_ff @(posedge clk) begin
        if (reset) begin
            pulse_s_p2    <= 1'b0;
            pulse_rise_p3 <= 1'b0;
        end else begin
            pulse_s_p2    <= pulse_s;
            pulse_rise_p3 <= pulse_s & ~pulse_s_p2;
        end
    end

    dcm_pwm #(.PWM_DIV(PWM_DIV)) u_pwm (
        .clk    (clk),
        .reset  (reset),
        .speed  (spd_q),
        .otw    (otw_s),
        .pwm_on (pwm_on)
    );

    always_comb begin
        pos_next = position_q;
        if (state == IDLE && cfg.cfg_zero)
            pos_next = '0;
        else if (pulse_rise_p3 && state != FAULT_RST)
            pos_next = (dir_q == DIR_RIGHT) ? position_q + POS_W'(1) : position_q - POS_W'(1);
    end

    // A load arriving this cycle overrides the stored target in every decision.
    assign tgt_eff  = cfg.cfg_load ? cfg.cfg_target : tgt_q;
    assign dir_eff  = dir_toward(tgt_eff, pos_next);
    assign drive_rl = !pwm_on ? 2'b00 : ((dir_q == DIR_RIGHT) ? 2'b10 : 2'b01);

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            dir_q           <= DIR_LEFT;
            position_q      <= '0;
            tgt_q           <= '0;
            spd_q           <= '0;
            tmr             <= '0;
            fault_latched_q <= 1'b0;
            motor_left      <= 1'b0;
            motor_right     <= 1'b0;
            motor_reset     <= 1'b0;
        end else begin
            position_q  <= pos_next;
            motor_left  <= 1'b0;
            motor_right <= 1'b0;
            if (fault_s && state != FAULT_RST) begin
                state           <= FAULT_RST;
                fault_latched_q <= 1'b1;
                motor_reset     <= 1'b1;
                tmr             <= '0;
            end else begin
                if (cfg.cfg_load && state != FAULT_RST) begin
                    spd_q <= cfg.cfg_speed;
                    tgt_q <= cfg.cfg_target;
                end
                case (state)
                    IDLE: begin
                        if (cfg.cfg_load) begin
                            fault_latched_q <= 1'b0;
                            if (tgt_eff != pos_next) begin
                                dir_q <= dir_eff;
                                tmr   <= '0;
                                state <= DRIVE;
                            end
                        end
                    end
                    DRIVE: begin
                        tmr <= (pulse_rise_p3 || spd_q == '0) ? '0 : tmr + TMR_W'(1);
                        if (tgt_eff == pos_next || (cfg.cfg_load && dir_eff != dir_q)) begin
                            state <= BRAKE;
                            tmr   <= '0;
                        end else if (spd_q != '0 && !pulse_rise_p3 &&
                                     tmr == TMR_W'(STALL_CYCLES - 1)) begin
                            state           <= FAULT_RST;
                            fault_latched_q <= 1'b1;
                            motor_reset     <= 1'b1;
                            tmr             <= '0;
                        end else begin
                            {motor_right, motor_left} <= drive_rl;
                        end
                    end
                    BRAKE: begin
                        if (tmr == TMR_W'(SETTLE_CYCLES - 1)) begin
                            tmr <= '0;
                            if (tgt_eff != pos_next) begin
                                dir_q <= dir_eff;
                                state <= DRIVE;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            tmr <= tmr + TMR_W'(1);
                        end
                    end
                    FAULT_RST: begin
                        // motor_reset doubles as the "reset pulse still running" phase flag.
                        if (motor_reset) begin
                            tmr <= tmr + TMR_W'(1);
                            if (tmr == TMR_W'(RESET_CYCLES - 1))
                                motor_reset <= 1'b0;
                        end else if (!fault_s) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign cfg.position      = position_q;
    assign cfg.busy          = (state != IDLE);
    assign cfg.fault_latched = fault_latched_q;
endmodule

// File: tb/tb_dcm_channel_ctrl.sv
// Directed bench for dcm_channel_ctrl with a pulse-history position model
// and hand-computed duty, timing and position expectations.
module tb_dcm_channel_ctrl;
    localparam int GAP = 64;

    logic clk = 1'b0;
    logic reset, motor_pulse, motor_fault, motor_otw;
    logic motor_left, motor_right, motor_reset;

    dcm_channel_ctrl_if bus ();

    dcm_channel_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .cfg         (bus),
        .motor_pulse (motor_pulse),
        .motor_fault (motor_fault),
        .motor_otw   (motor_otw),
        .motor_left  (motor_left),
        .motor_right (motor_right),
        .motor_reset (motor_reset)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic        cmp_en = 1'b0;
    logic        meas_en = 1'b0;
    int          r_cnt, l_cnt;
    logic        model_right = 1'b0;
    logic [23:0] pos_base = '0;
    logic [23:0] pulse_sum;
    logic [4:0]  hist;
    logic [23:0] exp_pos;

    assign exp_pos = pos_base + pulse_sum;

    // Position model: a pulse pin sampled rising at edge k moves the count at edge k+3,
    // in the direction the bench last commanded.
    always @(posedge clk) begin
        if (reset) begin
            hist      = '0;
            pulse_sum = '0;
        end else begin
            hist = {hist[3:0], motor_pulse};
            if (hist[3] && !hist[4])
                pulse_sum = model_right ? pulse_sum + 24'd1 : pulse_sum - 24'd1;
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_range(input string nm, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s got %0d expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                check("position", int'(bus.position), int'(exp_pos));
                check("both_outputs", int'(motor_left & motor_right), 0);
                if (!bus.busy) check("idle_outputs", int'({motor_left, motor_right}), 0);
                if (meas_en) begin
                    r_cnt += int'(motor_right);
                    l_cnt += int'(motor_left);
                end
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] s, input logic [23:0] t);
        bus.cfg_speed  = s;
        bus.cfg_target = t;
        bus.cfg_load   = 1'b1;
        tick(1);
        bus.cfg_load   = 1'b0;
    endtask

    task automatic feed(input int n);
        repeat (n) begin
            motor_pulse = 1'b1;
            tick(3);
            motor_pulse = 1'b0;
            tick(GAP - 3);
        end
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (bus.busy && n < bound) begin
            tick(1);
            n++;
        end
    endtask

    task automatic measure(input int len);
        r_cnt = 0;
        l_cnt = 0;
        meas_en = 1'b1;
        tick(len);
        meas_en = 1'b0;
    endtask

    initial begin
        int n, bad;
        reset = 1'b1;
        motor_pulse = 1'b0;
        motor_fault = 1'b0;
        motor_otw = 1'b0;
        bus.cfg_speed = '0;
        bus.cfg_target = '0;
        bus.cfg_load = 1'b0;
        bus.cfg_zero = 1'b0;
        r_cnt = 0;
        l_cnt = 0;
        fork
            compare_loop();
        join_none
        tick(10);
        reset = 1'b0;
        check("rst_left", int'(motor_left), 0);
        check("rst_right", int'(motor_right), 0);
        check("rst_mreset", int'(motor_reset), 0);
        check("rst_position", int'(bus.position), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_fault", int'(bus.fault_latched), 0);
        cmp_en = 1'b1;

        // Full speed to 20, pulses paced by the bench.
        model_right = 1'b1;
        load(8'd255, 24'd20);
        tick(2);
        r_cnt = 0;
        l_cnt = 0;
        meas_en = 1'b1;
        feed(19);
        meas_en = 1'b0;
        check_range("full_speed_right_hi", r_cnt, 19 * GAP - 8, 19 * GAP);
        check("full_speed_left_hi", l_cnt, 0);
        motor_pulse = 1'b1;
        tick(3);
        motor_pulse = 1'b0;
        tick(1);
        check("drop_after_20th", int'(motor_right), 0);
        check("pos_20", int'(bus.position), 20);
        n = 0;
        bad = 0;
        while (bus.busy && n < 3000) begin
            if (motor_left || motor_right) bad++;
            n++;
            tick(1);
        end
        check_range("brake_len", n, 1024, 1025);
        check("brake_outputs", bad, 0);
        check("idle_pos_20", int'(bus.position), 20);

        // Reversal mid-move: 20 -> toward 40, then retarget to 5.
        load(8'd255, 24'd40);
        feed(3);
        check("pos_23", int'(bus.position), 23);
        load(8'd255, 24'd5);
        model_right = 1'b0;
        n = 0;
        bad = 0;
        while (!motor_left && n < 3000) begin
            if (motor_right) bad++;
            n++;
            tick(1);
        end
        check_range("reverse_low_len", n, 1024, 1100);
        check("reverse_right_during_brake", bad, 0);
        feed(18);
        wait_idle(3000);
        check("pos_5", int'(bus.position), 5);
        check("rev_idle_busy", int'(bus.busy), 0);

        // Driver fault during a move.
        model_right = 1'b1;
        load(8'd200, 24'd100);
        feed(3);
        bus.cfg_zero = 1'b1;
        tick(1);
        bus.cfg_zero = 1'b0;
        check("zero_ignored_pos_8", int'(bus.position), 8);
        motor_fault = 1'b1;
        tick(3);
        check("fault_outputs", int'({motor_left, motor_right}), 0);
        check("fault_latched", int'(bus.fault_latched), 1);
        n = 0;
        while (motor_reset && n < 1000) begin
            n++;
            if (n == 20) motor_fault = 1'b0;
            tick(1);
        end
        check("motor_reset_len", n, 256);
        tick(2);
        check("fault_idle_busy", int'(bus.busy), 0);
        check("fault_sticky", int'(bus.fault_latched), 1);
        check("fault_pos_8", int'(bus.position), 8);
        bus.cfg_zero = 1'b1;
        tick(1);
        bus.cfg_zero = 1'b0;
        pos_base = 24'd0 - pulse_sum;
        check("zero_pos", int'(bus.position), 0);

        // Duty at speed 100 with and without over-temperature.
        load(8'd100, 24'd1000);
        check("load_clears_fault", int'(bus.fault_latched), 0);
        tick(10);
        measure(2048);
        check("duty_100", r_cnt, 800);
        check("duty_100_left", l_cnt, 0);
        motor_otw = 1'b1;
        tick(10);
        measure(2048);
        check("duty_otw", r_cnt, 400);
        check("duty_otw_left", l_cnt, 0);
        motor_otw = 1'b0;
        load(8'd100, 24'd0);
        wait_idle(3000);
        check("same_pos_load_idle", int'(bus.busy), 0);

        // Stall with no encoder feedback.
        load(8'd50, 24'd10);
        n = 0;
        while (!bus.fault_latched && n < 70000) begin
            tick(1);
            n++;
        end
        check_range("stall_len", n, 65534, 65540);
        check("stall_pos", int'(bus.position), 0);
        check("stall_mreset", int'(motor_reset), 1);
        check("stall_outputs", int'({motor_left, motor_right}), 0);
        wait_idle(400);
        check("stall_recovered", int'(bus.busy), 0);

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
